// File: rtl/vga_text_renderer.sv
// Text-mode pixel generator: COLS x ROWS character/attribute buffer, external font ROM
// lookup, per-cell invert/blink, hardware buffer clear and a fixed 3-cycle pixel pipeline.
module vga_text_renderer #(
    parameter int unsigned GLYPH_W   = 8,
    parameter int unsigned GLYPH_H   = 16,
    parameter int unsigned COLS      = 16,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned CODE_W    = 5,
    parameter int unsigned BLINK_DIV = 30,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned GY_W  = $clog2(GLYPH_H)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               pix_x,
    input  logic [9:0]               pix_y,
    input  logic                     video_on,
    input  logic                     frame_tick,
    input  logic                     clear_req,
    input  logic                     wr_en,
    input  logic [COL_W-1:0]         wr_col,
    input  logic [ROW_W-1:0]         wr_row,
    input  logic [CODE_W-1:0]        wr_code,
    input  logic [1:0]               wr_attr,
    output logic                     wr_ready,
    output logic [CODE_W+GY_W-1:0]   glyph_addr,
    input  logic [GLYPH_W-1:0]       glyph_data,
    output logic                     pix_on,
    output logic                     pix_valid
);
    localparam int unsigned GX_W   = $clog2(GLYPH_W);
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned CELL_W = CODE_W + 2;
    localparam int unsigned FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [CELL_W-1:0]  mem_wdata;
    logic [CELL_W-1:0]  cell_mem_q [CELLS];

    logic [9:0]         px_q, px_d, py_q, py_d;
    logic               von1_q, von1_d;
    logic [31:0]        col, row;
    logic               in_rng;
    logic [IDX_W-1:0]   rd_idx;
    logic [CELL_W-1:0]  cell_q, cell_d;
    logic [GX_W-1:0]    gx_q, gx_d, bit_idx;
    logic [GY_W-1:0]    gy_q, gy_d;
    logic               inr_q, inr_d, von2_q, von2_d;
    logic               fg;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               blink_q, blink_d;
    logic               pix_on_q, pix_on_d, pix_valid_q, pix_valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (clear_req) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
        end else if (state_q == ST_CLEAR) begin
            if (32'(clr_idx_q) == CELLS - 1) begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
            end
        end
    end

    // The clear sweep owns the write port; host writes are only taken in IDLE.
    always_comb begin
        wr_ready  = (state_q == ST_IDLE);
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_en && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS)) begin
            mem_we    = 1'b1;
            mem_waddr = IDX_W'(32'(wr_row) * COLS + 32'(wr_col));
            mem_wdata = {wr_code, wr_attr};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            cell_mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read uses pre-edge contents, so a same-cycle write to the read cell is seen next read.
    always_comb begin
        px_d   = pix_x;
        py_d   = pix_y;
        von1_d = video_on;
        col    = 32'(px_q) >> GX_W;
        row    = 32'(py_q) >> GY_W;
        in_rng = (col < COLS) && (row < ROWS);
        rd_idx = in_rng ? IDX_W'(row * COLS + col) : '0;
        cell_d = cell_mem_q[rd_idx];
        gx_d   = px_q[GX_W-1:0];
        gy_d   = py_q[GY_W-1:0];
        inr_d  = in_rng;
        von2_d = von1_q;
    end

    assign glyph_addr = {cell_q[CELL_W-1:2], gy_q};

    always_comb begin
        bit_idx     = GX_W'(GLYPH_W - 1) - gx_q;
        fg          = glyph_data[bit_idx] & ~(cell_q[1] & blink_q);
        pix_on_d    = von2_q & inr_q & (fg ^ cell_q[0]);
        pix_valid_d = von2_q;
    end

    always_comb begin
        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        if (frame_tick) begin
            if (32'(fcnt_q) == BLINK_DIV - 1) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            px_q        <= '0;
            py_q        <= '0;
            von1_q      <= 1'b0;
            cell_q      <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            inr_q       <= 1'b0;
            von2_q      <= 1'b0;
            fcnt_q      <= '0;
            blink_q     <= 1'b0;
            pix_on_q    <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            von1_q      <= von1_d;
            cell_q      <= cell_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            inr_q       <= inr_d;
            von2_q      <= von2_d;
            fcnt_q      <= fcnt_d;
            blink_q     <= blink_d;
            pix_on_q    <= pix_on_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign pix_on    = pix_on_q;
    assign pix_valid = pix_valid_q;

endmodule
